// File: rtl/current_profile_seq.sv
// current_profile_seq: plays a charge -> hold -> discharge current profile on I,
// one phase after another, with each phase length counted in clk cycles.
// Optional build macro VLIMIT_EN adds the vout input and the lim_hit output.
// With VLIMIT_EN defined, CHARGE ends early once vout reaches V_MAX.
module current_profile_seq #(
  parameter real I_CHG = 1.0e-6,
  parameter real I_DIS = -1.0e-6,
  parameter int  W_CNT = 16
`ifdef VLIMIT_EN
  ,
  parameter real V_MAX = 1.0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [W_CNT-1:0] len_chg,
  input  logic [W_CNT-1:0] len_hold,
  input  logic [W_CNT-1:0] len_dis,
`ifdef VLIMIT_EN
  input  real              vout,
  output logic             lim_hit,
`endif
  output real              I,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHARGE = 3'd1,
    S_HOLD   = 3'd2,
    S_DIS    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic [W_CNT-1:0] lc_q, lc_d;
  logic [W_CNT-1:0] lh_q, lh_d;
  logic [W_CNT-1:0] ld_q, ld_d;
  logic             busy_d, done_d, aborted_d;
  real              i_d;
  logic             chg_end;
`ifdef VLIMIT_EN
  logic             lim_q, lim_d;
  logic             vlim;
`endif

  assign state = state_q;

  // State, counter, latched lengths and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lc_q    <= '0;
      lh_q    <= '0;
      ld_q    <= '0;
      I       <= 0.0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
`ifdef VLIMIT_EN
      lim_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lc_q    <= lc_d;
      lh_q    <= lh_d;
      ld_q    <= ld_d;
      I       <= i_d;
      busy    <= busy_d;
      done    <= done_d;
      aborted <= aborted_d;
`ifdef VLIMIT_EN
      lim_q   <= lim_d;
`endif
    end
  end

`ifdef VLIMIT_EN
  assign lim_hit = lim_q;
  assign vlim    = (vout >= V_MAX);
`endif

  // End of CHARGE: counter exhausted, or the voltage limit was reached
`ifdef VLIMIT_EN
  assign chg_end = (cnt_q == '0) || vlim;
`else
  assign chg_end = (cnt_q == '0);
`endif

  // Next-state, counter and output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lc_d      = lc_q;
    lh_d      = lh_q;
    ld_d      = ld_q;
    aborted_d = 1'b0;
`ifdef VLIMIT_EN
    lim_d     = lim_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          lc_d = len_chg;
          lh_d = len_hold;
          ld_d = len_dis;
`ifdef VLIMIT_EN
          lim_d = 1'b0;
`endif
          // Enter the first phase whose length is nonzero
          if (len_chg != '0) begin
            state_d = S_CHARGE;
            cnt_d   = len_chg - W_CNT'(1);
          end else if (len_hold != '0) begin
            state_d = S_HOLD;
            cnt_d   = len_hold - W_CNT'(1);
          end else if (len_dis != '0) begin
            state_d = S_DIS;
            cnt_d   = len_dis - W_CNT'(1);
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
      end

      S_CHARGE: begin
        if (abort) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (chg_end) begin
`ifdef VLIMIT_EN
          if (vlim) lim_d = 1'b1;
`endif
          if (lh_q != '0) begin
            state_d = S_HOLD;
            cnt_d   = lh_q - W_CNT'(1);
          end else if (ld_q != '0) begin
            state_d = S_DIS;
            cnt_d   = ld_q - W_CNT'(1);
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - W_CNT'(1);
        end
      end

      S_HOLD: begin
        if (abort) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          if (ld_q != '0) begin
            state_d = S_DIS;
            cnt_d   = ld_q - W_CNT'(1);
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - W_CNT'(1);
        end
      end

      S_DIS: begin
        if (abort) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - W_CNT'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the state being entered, so they change with state
    busy_d = (state_d == S_CHARGE) || (state_d == S_HOLD) || (state_d == S_DIS);
    done_d = (state_d == S_DONE);
    if (state_d == S_CHARGE)   i_d = I_CHG;
    else if (state_d == S_DIS) i_d = I_DIS;
    else                       i_d = 0.0;
  end

endmodule
